// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// writeback stage and the MUL/DIV unit. The pipeline wins by default; MDU
// results wait in a 2-entry FIFO, and a head that has waited STARVE_LIMIT
// cycles is forced through by stalling the pipeline for one cycle.
//
// MDU handshake: a transfer happens on any rising edge where mdu_valid_i and
// mdu_ready_o are both high. The MDU keeps valid, address and data stable
// until then, and mdu_ready_o never depends on mdu_valid_i.
//
// A pipeline write is always younger than anything queued, so when it
// targets a register that a queued (or just-accepted) MDU result also
// targets, that MDU result is marked dead and later drains without writing.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pipe_we_i,
  input  logic [4:0]      pipe_rd_addr_i,
  input  logic [XLEN-1:0] pipe_rd_data_i,
  input  logic            mdu_valid_i,
  output logic            mdu_ready_o,
  input  logic [4:0]      mdu_rd_addr_i,
  input  logic [XLEN-1:0] mdu_rd_data_i,
  output logic            stall_o,
  output logic            mdu_pending_o,
  output logic            rd_we_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Which requester owns the write port this cycle.
  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_FORCED,
    GNT_PIPE,
    GNT_HEAD,
    GNT_BYPASS
  } grant_e;

  grant_e grant;

  // FIFO state; occupancy is tracked apart from the live flags so dead
  // entries still hold their slot until popped.
  logic [1:0]            occ_q, occ_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            live_q, live_d;
  logic [1:0][4:0]       fifo_addr_q, fifo_addr_d;
  logic [1:0][XLEN-1:0]  fifo_data_q, fifo_data_d;
  logic [3:0]            starve_q, starve_d;

  logic                  pending_d;
  logic                  rd_we_d;
  logic [4:0]            rd_addr_d;
  logic [XLEN-1:0]       rd_data_d;

  logic                  occupied;
  logic                  pop;
  logic                  ready;
  logic                  push;
  logic                  kill_en;
  logic                  push_killed;

  assign occupied    = (occ_q != 2'd0);
  assign mdu_ready_o = ready;

  // Grant selection plus the handshake and kill decisions that follow from it.
  always_comb begin
    grant       = GNT_NONE;
    pop         = 1'b0;
    stall_o     = 1'b0;
    ready       = 1'b0;
    push        = 1'b0;
    kill_en     = 1'b0;
    push_killed = 1'b0;

    if (occupied && (starve_q == STARVE_MAX)) begin
      grant = GNT_FORCED;
    end else if (pipe_we_i) begin
      grant = GNT_PIPE;
    end else if (occupied) begin
      grant = GNT_HEAD;
    end else if (mdu_valid_i) begin
      grant = GNT_BYPASS;
    end

    pop     = (grant == GNT_FORCED) || (grant == GNT_HEAD);
    stall_o = (grant == GNT_FORCED) && pipe_we_i;

    // A full FIFO can still accept when its head leaves this same cycle.
    ready = (occ_q != 2'd2) || pop;

    // Bypassed results go straight to the port and never occupy a slot.
    push = mdu_valid_i && ready && (grant != GNT_BYPASS);

    // Register x0 is never written, so a pipeline write to it kills nothing.
    kill_en     = (grant == GNT_PIPE) && (pipe_rd_addr_i != 5'd0);
    push_killed = kill_en && (mdu_rd_addr_i == pipe_rd_addr_i);
  end

  // FIFO next state: kill matching entries, retire the head, append the tail.
  always_comb begin
    live_d      = live_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
    pending_d   = 1'b0;

    if (kill_en) begin
      for (int i = 0; i < 2; i++) begin
        if (fifo_addr_q[i] == pipe_rd_addr_i) begin
          live_d[i] = 1'b0;
        end
      end
    end

    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = ~head_q;
    end

    // When full and popping, tail equals head, so the push reuses the slot
    // just retired above.
    if (push) begin
      live_d[tail_q]      = ~push_killed;
      fifo_addr_d[tail_q] = mdu_rd_addr_i;
      fifo_data_d[tail_q] = mdu_rd_data_i;
      tail_d              = ~tail_q;
    end

    pending_d = |live_d;
  end

  // Starvation counter: counts cycles the head sits unpopped, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!occupied || pop) begin
      starve_d = 4'd0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Next register-file write; address and data hold when nothing is granted.
  always_comb begin
    rd_we_d   = 1'b0;
    rd_addr_d = rd_addr_o;
    rd_data_d = rd_data_o;
    unique case (grant)
      GNT_FORCED, GNT_HEAD: begin
        rd_we_d   = live_q[head_q] && (fifo_addr_q[head_q] != 5'd0);
        rd_addr_d = fifo_addr_q[head_q];
        rd_data_d = fifo_data_q[head_q];
      end
      GNT_PIPE: begin
        rd_we_d   = (pipe_rd_addr_i != 5'd0);
        rd_addr_d = pipe_rd_addr_i;
        rd_data_d = pipe_rd_data_i;
      end
      GNT_BYPASS: begin
        rd_we_d   = (mdu_rd_addr_i != 5'd0);
        rd_addr_d = mdu_rd_addr_i;
        rd_data_d = mdu_rd_data_i;
      end
      default: begin
      end
    endcase
  end

  // FIFO and starvation state registers; reset drops every queued entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q       <= 2'd0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      live_q      <= 2'b00;
      fifo_addr_q <= '0;
      fifo_data_q <= '0;
      starve_q    <= 4'd0;
    end else begin
      occ_q       <= occ_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      live_q      <= live_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      starve_q    <= starve_d;
    end
  end

  // Registered write port and pending flag, one cycle after the grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_we_o       <= 1'b0;
      rd_addr_o     <= 5'd0;
      rd_data_o     <= '0;
      mdu_pending_o <= 1'b0;
    end else begin
      rd_we_o       <= rd_we_d;
      rd_addr_o     <= rd_addr_d;
      rd_data_o     <= rd_data_d;
      mdu_pending_o <= pending_d;
    end
  end

endmodule
